// File: rtl/loader_pkg.sv
// Shared types and image-format constants for the serial program loader.
`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 12
`endif

package loader_pkg;

    localparam int unsigned COUNT_BYTES = 4;
    localparam int unsigned WORD_BYTES  = 4;

    typedef enum logic [2:0] {
        RECV_COUNT,
        RECV_WORD,
        WRITE,
        DONE,
        ERROR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start detect.
module uart_rx
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    uart_state_e state_q, state_d;
    logic        sync1_q, sync2_q, prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RX_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A line that is high again at mid start bit was a glitch.
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    data_d = {sync2_q, data_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_data  = data_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/program_loader.sv
// Receives a length-prefixed program image over UART and writes it into instruction ROM.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ROM_WORDS    = 2 ** (`ROM_ADDRESS_BITWIDTH - 2)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             uart_rx,
    output logic                             rom_wren,
    output logic [`ROM_ADDRESS_BITWIDTH-1:0] rom_address,
    output logic [31:0]                      rom_write_data,
    output logic                             cpu_reset_n,
    output logic                             loading,
    output logic                             error
);

    localparam int unsigned AW = `ROM_ADDRESS_BITWIDTH;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (uart_rx),
        .byte_data (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_ferr)
    );

    loader_state_e   state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [31:0]     shift_q, shift_d;
    logic [31:0]     count_q, count_d;
    logic [AW-3:0]   word_idx_q, word_idx_d;
    logic            rom_wren_q, rom_wren_d;
    logic [AW-1:0]   rom_address_q, rom_address_d;
    logic [31:0]     rom_data_q, rom_data_d;
    logic            cpu_reset_n_q, cpu_reset_n_d;
    logic            loading_q, loading_d;
    logic            error_q, error_d;
    logic [31:0]     assembled;

    assign assembled = {rx_byte, shift_q[31:8]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= RECV_COUNT;
            byte_cnt_q    <= '0;
            shift_q       <= '0;
            count_q       <= '0;
            word_idx_q    <= '0;
            rom_wren_q    <= 1'b0;
            rom_address_q <= '0;
            rom_data_q    <= '0;
            cpu_reset_n_q <= 1'b0;
            loading_q     <= 1'b1;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            shift_q       <= shift_d;
            count_q       <= count_d;
            word_idx_q    <= word_idx_d;
            rom_wren_q    <= rom_wren_d;
            rom_address_q <= rom_address_d;
            rom_data_q    <= rom_data_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            loading_q     <= loading_d;
            error_q       <= error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        shift_d       = shift_q;
        count_d       = count_q;
        word_idx_d    = word_idx_q;
        rom_wren_d    = 1'b0;
        rom_address_d = rom_address_q;
        rom_data_d    = rom_data_q;
        case (state_q)
            RECV_COUNT: begin
                if (rx_ferr) begin
                    state_d = ERROR;
                end else if (rx_valid) begin
                    shift_d = assembled;
                    if (byte_cnt_q == 2'(COUNT_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        count_d    = assembled;
                        if (assembled == 32'd0)           state_d = DONE;
                        else if (assembled > ROM_WORDS)   state_d = ERROR;
                        else                              state_d = RECV_WORD;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            RECV_WORD: begin
                if (rx_ferr) begin
                    state_d = ERROR;
                end else if (rx_valid) begin
                    shift_d = assembled;
                    if (byte_cnt_q == 2'(WORD_BYTES - 1)) begin
                        // Write strobe is registered here so it is high during the WRITE cycle.
                        byte_cnt_d    = '0;
                        state_d       = WRITE;
                        rom_wren_d    = 1'b1;
                        rom_address_d = {word_idx_q, 2'b00};
                        rom_data_d    = assembled;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                if (32'(word_idx_q) + 32'd1 == count_q) begin
                    state_d = DONE;
                end else begin
                    word_idx_d = word_idx_q + 1'b1;
                    state_d    = RECV_WORD;
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
    end

    always_comb begin
        cpu_reset_n_d = (state_d == DONE);
        loading_d     = (state_d != DONE) && (state_d != ERROR);
        error_d       = (state_d == ERROR);
    end

    assign rom_wren       = rom_wren_q;
    assign rom_address    = rom_address_q;
    assign rom_write_data = rom_data_q;
    assign cpu_reset_n    = cpu_reset_n_q;
    assign loading        = loading_q;
    assign error          = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed-vector bench for program_loader with CLKS_PER_BIT=4, ROM_WORDS=16.
`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 12
`endif

module tb_program_loader;

    localparam int CPB = 4;
    localparam int AW  = `ROM_ADDRESS_BITWIDTH;
    localparam int NV  = 7;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          uart_rx = 1'b1;
    logic          rom_wren;
    logic [AW-1:0] rom_address;
    logic [31:0]   rom_write_data;
    logic          cpu_reset_n;
    logic          loading;
    logic          error;

    program_loader #(
        .CLKS_PER_BIT(CPB),
        .ROM_WORDS   (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .uart_rx       (uart_rx),
        .rom_wren      (rom_wren),
        .rom_address   (rom_address),
        .rom_write_data(rom_write_data),
        .cpu_reset_n   (cpu_reset_n),
        .loading       (loading),
        .error         (error)
    );

    always #5 clk = ~clk;

    // Write monitor: logs every strobe and the cycle cpu_reset_n rises.
    int          cyc = 0;
    int          wr_cnt = 0;
    int          b2b_cnt = 0;
    int          last_wr_cyc = 0;
    int          rise_cyc = -100;
    logic        prev_wren = 1'b0;
    logic        prev_crn = 1'b0;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_wren <= rom_wren;
        prev_crn  <= cpu_reset_n;
        if (rom_wren) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] <= 32'(rom_address);
                wr_data[wr_cnt] <= rom_write_data;
            end
            wr_cnt      <= wr_cnt + 1;
            last_wr_cyc <= cyc;
            if (prev_wren) b2b_cnt <= b2b_cnt + 1;
        end
        if (cpu_reset_n && !prev_crn) rise_cyc <= cyc;
    end

    typedef struct {
        string        name;
        int           nbytes;
        logic [95:0]  bytes;
        int           bad_idx;
        int           exp_n;
        logic [31:0]  exp_a0, exp_d0, exp_a1, exp_d1;
        logic         exp_err, exp_crn, exp_load;
    } vec_t;

    vec_t vecs [NV];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic line_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        line_bit(stop);
        line_bit(1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        uart_rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int k, input string nm, input int nb, input logic [95:0] by,
                           input int bad, input int n, input logic [31:0] a0, input logic [31:0] d0,
                           input logic [31:0] a1, input logic [31:0] d1,
                           input logic er, input logic crn, input logic ld);
        vecs[k].name = nm; vecs[k].nbytes = nb; vecs[k].bytes = by; vecs[k].bad_idx = bad;
        vecs[k].exp_n = n; vecs[k].exp_a0 = a0; vecs[k].exp_d0 = d0;
        vecs[k].exp_a1 = a1; vecs[k].exp_d1 = d1;
        vecs[k].exp_err = er; vecs[k].exp_crn = crn; vecs[k].exp_load = ld;
    endtask

    int base, b2b_base;

    initial begin
        // Byte 0 of each stream is in bits 7:0.
        set_vec(0, "two_words", 12, 96'hDEADBEEF_00000013_00000002, -1, 2,
                32'h0, 32'h00000013, 32'h4, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        set_vec(1, "zero_count", 5, 96'h55_00000000, -1, 0,
                '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        set_vec(2, "word_ferr", 10, 96'hDDCC_BBAA0000_13_00000003, 5, 0,
                '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        set_vec(3, "count_17", 8, 96'h00000013_00000011, -1, 0,
                '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        set_vec(4, "one_word", 8, 96'h12345678_00000001, -1, 1,
                32'h0, 32'h12345678, '0, '0, 1'b0, 1'b1, 1'b0);
        set_vec(5, "count_256", 4, 96'h00000100, -1, 0,
                '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        set_vec(6, "count_ferr", 4, 96'h00000001, 0, 0,
                '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_wren", 32'(rom_wren), 32'd0);
        chk("reset_addr", 32'(rom_address), 32'd0);
        chk("reset_data", rom_write_data, 32'd0);
        chk("reset_crn", 32'(cpu_reset_n), 32'd0);
        chk("reset_loading", 32'(loading), 32'd1);
        chk("reset_error", 32'(error), 32'd0);

        for (int v = 0; v < NV; v++) begin
            do_reset();
            base     = wr_cnt;
            b2b_base = b2b_cnt;
            for (int i = 0; i < vecs[v].nbytes; i++)
                send_byte(vecs[v].bytes[i*8 +: 8], i != vecs[v].bad_idx);
            repeat (20) @(posedge clk);
            @(negedge clk);
            chk({vecs[v].name, "_nwr"}, 32'(wr_cnt - base), 32'(vecs[v].exp_n));
            if (vecs[v].exp_n >= 1 && wr_cnt - base >= 1) begin
                chk({vecs[v].name, "_a0"}, wr_addr[base], vecs[v].exp_a0);
                chk({vecs[v].name, "_d0"}, wr_data[base], vecs[v].exp_d0);
            end
            if (vecs[v].exp_n >= 2 && wr_cnt - base >= 2) begin
                chk({vecs[v].name, "_a1"}, wr_addr[base+1], vecs[v].exp_a1);
                chk({vecs[v].name, "_d1"}, wr_data[base+1], vecs[v].exp_d1);
            end
            chk({vecs[v].name, "_err"}, 32'(error), 32'(vecs[v].exp_err));
            chk({vecs[v].name, "_crn"}, 32'(cpu_reset_n), 32'(vecs[v].exp_crn));
            chk({vecs[v].name, "_load"}, 32'(loading), 32'(vecs[v].exp_load));
            chk({vecs[v].name, "_b2b"}, 32'(b2b_cnt - b2b_base), 32'd0);
            if (vecs[v].exp_crn && vecs[v].exp_n > 0)
                chk({vecs[v].name, "_crn_lat"}, 32'(rise_cyc - last_wr_cyc), 32'd1);
        end

        // cpu_reset_n must rise only once the 4th zero count byte lands.
        do_reset();
        base = wr_cnt;
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        @(negedge clk);
        chk("zc_crn_before", 32'(cpu_reset_n), 32'd0);
        chk("zc_load_before", 32'(loading), 32'd1);
        send_byte(8'h00, 1'b1);
        @(negedge clk);
        chk("zc_crn_after", 32'(cpu_reset_n), 32'd1);
        send_byte(8'h55, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("zc_crn_hold", 32'(cpu_reset_n), 32'd1);
        chk("zc_load_hold", 32'(loading), 32'd0);
        chk("zc_nwr", 32'(wr_cnt - base), 32'd0);

        // Reset pulse in the middle of word 1, then a full resend.
        do_reset();
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h22, 1'b1);
        line_bit(1'b0);
        line_bit(1'b1);
        line_bit(1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_wren", 32'(rom_wren), 32'd0);
        chk("mid_rst_addr", 32'(rom_address), 32'd0);
        chk("mid_rst_data", rom_write_data, 32'd0);
        chk("mid_rst_crn", 32'(cpu_reset_n), 32'd0);
        chk("mid_rst_loading", 32'(loading), 32'd1);
        chk("mid_rst_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        uart_rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        base = wr_cnt;
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("resend_nwr", 32'(wr_cnt - base), 32'd2);
        if (wr_cnt - base >= 2) begin
            chk("resend_a0", wr_addr[base], 32'h0);
            chk("resend_d0", wr_data[base], 32'hDDCCBBAA);
            chk("resend_a1", wr_addr[base+1], 32'h4);
            chk("resend_d1", wr_data[base+1], 32'h04030201);
        end
        chk("resend_crn", 32'(cpu_reset_n), 32'd1);

        // A one-clock low glitch on an idle line must not start a byte.
        do_reset();
        base = wr_cnt;
        uart_rx = 1'b0;
        @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("glitch_load", 32'(loading), 32'd1);
        chk("glitch_err", 32'(error), 32'd0);
        chk("glitch_crn", 32'(cpu_reset_n), 32'd0);
        #1;
        send_byte(8'h01, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("glitch_nwr", 32'(wr_cnt - base), 32'd1);
        if (wr_cnt - base >= 1) begin
            chk("glitch_a0", wr_addr[base], 32'h0);
            chk("glitch_d0", wr_data[base], 32'hDEADBEEF);
        end
        chk("glitch_crn_done", 32'(cpu_reset_n), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
